// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding, owner IDs,
// the captured command record and the abort read value.
package mem_arb_pkg;
  localparam int IDLE  = 0;
  localparam int ISSUE = 1;
  localparam int WAIT  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'(1 << IDLE),
    S_ISSUE = 3'(1 << ISSUE),
    S_WAIT  = 3'(1 << WAIT)
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [7:0] RDATA_ERR = 8'hFF;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;
endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-controller signals of the arbiter, bundled.
// slave = arbiter side, master = requesters plus controller side.
interface mem_arb_if;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_done;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        timeout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en, mem_busy, mem_done;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_busy, mem_done, mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    output dma_gnt, dma_done, dma_rdata,
    output timeout, mem_addr, mem_wdata, mem_read_en, mem_write_en
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_busy, mem_done, mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  timeout, mem_addr, mem_wdata, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Fixed CPU priority with a starvation bound: after STARVE_MAX CPU grants while
// DMA is waiting, DMA is forced to win the next arbitration.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  input  logic i_gnt_evt,
  input  logic i_win,
  output logic o_win
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] r_starve;
  logic       w_starved;

  assign w_starved = (r_starve == SMAX);
  assign o_win     = (i_dma_req && (!i_cpu_req || w_starved)) ? OWN_DMA : OWN_CPU;

  // Any cycle without a DMA request breaks the streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_starve <= '0;
    else if (!i_dma_req || (i_gnt_evt && i_win == OWN_DMA)) r_starve <= '0;
    else if (i_gnt_evt && !w_starved) r_starve <= r_starve + 4'd1;
  end
endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter/sequencer in front of the memory controller: grant, one-cycle
// strobe, wait for completion (bounded by a watchdog), return done/rdata.
module mem_arb #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb_if.slave  bus
);
  import mem_arb_pkg::*;

  localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit         TO_EN   = (TIMEOUT != 0);

  state_t      r_state, w_next;
  logic        r_owner, w_owner;
  cmd_t        r_cmd, w_cmd, w_sel;
  logic [7:0]  r_wd_cnt, w_wd_cnt;
  logic        r_cpu_gnt, r_dma_gnt, r_cpu_done, r_dma_done, r_timeout, r_rd_en, r_wr_en;
  logic        w_cpu_gnt, w_dma_gnt, w_cpu_done, w_dma_done, w_timeout, w_rd_en, w_wr_en;
  logic [7:0]  r_cpu_rdata, r_dma_rdata, w_cpu_rdata, w_dma_rdata;
  logic        w_gnt_evt, w_win, w_fin;
  logic [7:0]  w_fin_data;

  assign w_gnt_evt = r_state[IDLE] && !bus.mem_busy && (bus.cpu_req || bus.dma_req);

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .reset     (reset),
    .i_cpu_req (bus.cpu_req),
    .i_dma_req (bus.dma_req),
    .i_gnt_evt (w_gnt_evt),
    .i_win     (w_win),
    .o_win     (w_win)
  );

  assign w_sel = (w_win == OWN_DMA) ? '{bus.dma_we, bus.dma_addr, bus.dma_wdata}
                                    : '{bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};

  always_comb begin
    w_next      = r_state;
    w_owner     = r_owner;
    w_cmd       = r_cmd;
    w_wd_cnt    = r_wd_cnt;
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_cpu_done  = 1'b0;
    w_dma_done  = 1'b0;
    w_timeout   = 1'b0;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_cpu_rdata = r_cpu_rdata;
    w_dma_rdata = r_dma_rdata;
    w_fin       = 1'b0;
    w_fin_data  = bus.mem_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_evt) begin
          w_next    = S_ISSUE;
          w_owner   = w_win;
          w_cmd     = w_sel;
          w_cpu_gnt = (w_win == OWN_CPU);
          w_dma_gnt = (w_win == OWN_DMA);
          w_rd_en   = !w_sel.we;
          w_wr_en   = w_sel.we;
        end
      end
      S_ISSUE: begin
        w_next   = S_WAIT;
        w_wd_cnt = '0;
      end
      S_WAIT: begin
        // Completion beats a watchdog expiry landing in the same cycle.
        if (bus.mem_done) begin
          w_fin = 1'b1;
        end else if (TO_EN && r_wd_cnt == TO_LAST) begin
          w_fin      = 1'b1;
          w_timeout  = 1'b1;
          w_fin_data = RDATA_ERR;
        end else begin
          w_wd_cnt = r_wd_cnt + 8'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_fin) begin
      w_next     = S_IDLE;
      w_cpu_done = (r_owner == OWN_CPU);
      w_dma_done = (r_owner == OWN_DMA);
      if (!r_cmd.we) begin
        if (r_owner == OWN_CPU) w_cpu_rdata = w_fin_data;
        else                    w_dma_rdata = w_fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_CPU;
      r_cmd       <= '0;
      r_wd_cnt    <= '0;
      r_cpu_gnt   <= 1'b0;
      r_dma_gnt   <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_timeout   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_owner     <= w_owner;
      r_cmd       <= w_cmd;
      r_wd_cnt    <= w_wd_cnt;
      r_cpu_gnt   <= w_cpu_gnt;
      r_dma_gnt   <= w_dma_gnt;
      r_cpu_done  <= w_cpu_done;
      r_dma_done  <= w_dma_done;
      r_timeout   <= w_timeout;
      r_rd_en     <= w_rd_en;
      r_wr_en     <= w_wr_en;
      r_cpu_rdata <= w_cpu_rdata;
      r_dma_rdata <= w_dma_rdata;
    end
  end

  assign bus.cpu_gnt      = r_cpu_gnt;
  assign bus.dma_gnt      = r_dma_gnt;
  assign bus.cpu_done     = r_cpu_done;
  assign bus.dma_done     = r_dma_done;
  assign bus.cpu_rdata    = r_cpu_rdata;
  assign bus.dma_rdata    = r_dma_rdata;
  assign bus.timeout      = r_timeout;
  assign bus.mem_addr     = r_cmd.addr;
  assign bus.mem_wdata    = r_cmd.wdata;
  assign bus.mem_read_en  = r_rd_en;
  assign bus.mem_write_en = r_wr_en;
endmodule

// File: tb/tb_mem_arb.sv
// Directed and randomized bench for mem_arb against a transaction-level model
// of the arbitration, starvation and watchdog rules.
module tb_mem_arb;
  localparam int TO   = 8;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_if ifc ();
  mem_arb #(.STARVE_MAX(SMAX), .TIMEOUT(TO)) dut (.clk(clk), .reset(rst_n), .bus(ifc));

  int checks = 0, failures = 0;
  int streak = 0;
  bit pend_c = 0, pend_d = 0;
  logic        c_we = 0, d_we = 0;
  logic [15:0] c_addr = 0, d_addr = 0;
  logic [7:0]  c_wd = 0, d_wd = 0;
  logic [7:0]  exp_crd = 0, exp_drd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cgnt"}, ifc.cpu_gnt, 0);
    chk({tag, "_dgnt"}, ifc.dma_gnt, 0);
    chk({tag, "_rden"}, ifc.mem_read_en, 0);
    chk({tag, "_wren"}, ifc.mem_write_en, 0);
    chk({tag, "_cdone"}, ifc.cpu_done, 0);
    chk({tag, "_ddone"}, ifc.dma_done, 0);
    chk({tag, "_tmo"}, ifc.timeout, 0);
  endtask

  // One arbitration + transaction. lat = WAIT cycle (1-based) carrying mem_done;
  // outside 1..TO means no completion. early drives mem_done during ISSUE.
  task automatic run_txn(input bit hold, input int lat, input logic [7:0] rd,
                         input bit early, output bit won);
    logic ew; logic [15:0] ea; logic [7:0] ed; bit to; int end_k;
    ifc.cpu_req = pend_c; ifc.cpu_we = c_we; ifc.cpu_addr = c_addr; ifc.cpu_wdata = c_wd;
    ifc.dma_req = pend_d; ifc.dma_we = d_we; ifc.dma_addr = d_addr; ifc.dma_wdata = d_wd;
    won = pend_d && (!pend_c || streak == SMAX);
    ew = won ? d_we : c_we;
    ea = won ? d_addr : c_addr;
    ed = won ? d_wd : c_wd;
    tick();
    chk("gnt_cpu", ifc.cpu_gnt, !won);
    chk("gnt_dma", ifc.dma_gnt, won);
    chk("strobe_rd", ifc.mem_read_en, !ew);
    chk("strobe_wr", ifc.mem_write_en, ew);
    chk("issue_addr", ifc.mem_addr, ea);
    chk("issue_wdata", ifc.mem_wdata, ed);
    chk("issue_done", ifc.cpu_done | ifc.dma_done | ifc.timeout, 0);
    if (won) streak = 0;
    else if (pend_d) streak = (streak < SMAX) ? streak + 1 : SMAX;
    if (!hold) begin
      if (won) pend_d = 0; else pend_c = 0;
    end
    ifc.cpu_req = pend_c;
    ifc.dma_req = pend_d;
    if (!pend_d) streak = 0;
    ifc.mem_done  = early;
    ifc.mem_rdata = ~rd;
    to    = !(lat >= 1 && lat <= TO);
    end_k = to ? TO : lat;
    for (int k = 1; k <= end_k; k++) begin
      tick();
      chk_quiet("wait");
      chk("wait_addr", ifc.mem_addr, ea);
      chk("wait_wdata", ifc.mem_wdata, ed);
      ifc.mem_done  = (k == lat);
      ifc.mem_rdata = rd;
    end
    tick();
    ifc.mem_done = 0;
    chk("done_cpu", ifc.cpu_done, !won);
    chk("done_dma", ifc.dma_done, won);
    chk("timeout", ifc.timeout, to);
    chk("done_strobes", ifc.mem_read_en | ifc.mem_write_en | ifc.cpu_gnt | ifc.dma_gnt, 0);
    if (!ew) begin
      if (won) exp_drd = to ? 8'hFF : rd;
      else     exp_crd = to ? 8'hFF : rd;
    end
    chk("cpu_rdata", ifc.cpu_rdata, exp_crd);
    chk("dma_rdata", ifc.dma_rdata, exp_drd);
  endtask

  initial begin
    bit w;
    rst_n = 1'b0;
    ifc.cpu_req = 0; ifc.cpu_we = 0; ifc.cpu_addr = 0; ifc.cpu_wdata = 0;
    ifc.dma_req = 0; ifc.dma_we = 0; ifc.dma_addr = 0; ifc.dma_wdata = 0;
    ifc.mem_busy = 0; ifc.mem_done = 0; ifc.mem_rdata = 0;
    tick(); tick();
    chk_quiet("rst");
    chk("rst_addr", ifc.mem_addr, 0);
    chk("rst_wdata", ifc.mem_wdata, 0);
    chk("rst_crd", ifc.cpu_rdata, 0);
    chk("rst_drd", ifc.dma_rdata, 0);
    rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    // CPU read alone, completion in the second WAIT cycle.
    pend_c = 1; c_we = 0; c_addr = 16'h1234; c_wd = 8'h00;
    run_txn(0, 2, 8'hA5, 0, w);
    chk("cpu_read_win", w, 0);
    chk("cpu_read_rdata", ifc.cpu_rdata, 8'hA5);

    // Contention: both held, expect CPU x4 then DMA, twice.
    pend_c = 1; c_we = 0; c_addr = 16'h0100;
    pend_d = 1; d_we = 1; d_addr = 16'h0200; d_wd = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      run_txn(1, 1 + (i % 3), 8'(8'h10 + i), 0, w);
      chk("contention_order", w, (i % 5) == 4);
    end
    pend_c = 0; pend_d = 0;
    ifc.cpu_req = 0; ifc.dma_req = 0;
    tick();
    streak = 0;
    chk_quiet("post_cont");

    // Busy blocks arbitration.
    ifc.mem_busy = 1; ifc.cpu_req = 1; ifc.cpu_we = 1; ifc.cpu_addr = 16'h4444; ifc.cpu_wdata = 8'h77;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("busy");
    end
    ifc.mem_busy = 0;
    pend_c = 1; c_we = 1; c_addr = 16'h4444; c_wd = 8'h77;
    run_txn(0, 3, 8'h00, 0, w);

    // Watchdog: DMA write, no completion.
    pend_d = 1; d_we = 1; d_addr = 16'hFFFF; d_wd = 8'h3C;
    run_txn(0, 0, 8'h00, 0, w);
    chk("wd_win", w, 1);

    // Watchdog on a read, then completion colliding with expiry.
    pend_d = 1; d_we = 0; d_addr = 16'h00F0;
    run_txn(0, 0, 8'h00, 0, w);
    chk("wd_read_err", ifc.dma_rdata, 8'hFF);
    pend_c = 1; c_we = 0; c_addr = 16'h2222;
    run_txn(0, TO, 8'hC3, 0, w);
    chk("collide_rdata", ifc.cpu_rdata, 8'hC3);

    // mem_done during ISSUE must be ignored.
    pend_c = 1; c_we = 0; c_addr = 16'h3333;
    run_txn(0, 4, 8'h9E, 1, w);

    // Reset during WAIT of a CPU read.
    ifc.cpu_req = 1; ifc.cpu_we = 0; ifc.cpu_addr = 16'h0BEE;
    tick();
    chk("rw_gnt", ifc.cpu_gnt, 1);
    ifc.cpu_req = 0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_quiet("rw_rst");
    chk("rw_addr", ifc.mem_addr, 0);
    chk("rw_wdata", ifc.mem_wdata, 0);
    chk("rw_crd", ifc.cpu_rdata, 0);
    chk("rw_drd", ifc.dma_rdata, 0);
    exp_crd = 0; exp_drd = 0; streak = 0;
    tick();
    rst_n = 1'b1;
    ifc.mem_done = 1; ifc.mem_rdata = 8'h77;
    tick();
    ifc.mem_done = 0;
    chk_quiet("rw_after1");
    tick();
    chk_quiet("rw_after2");
    pend_c = 1; c_we = 0; c_addr = 16'h5678;
    run_txn(0, 1, 8'h42, 0, w);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (!pend_c && $urandom_range(0, 3) != 0) begin
        pend_c = 1; c_we = 1'($urandom); c_addr = 16'($urandom); c_wd = 8'($urandom);
      end
      if (!pend_d && $urandom_range(0, 1) != 0) begin
        pend_d = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wd = 8'($urandom);
      end
      if (!pend_c && !pend_d) begin
        pend_d = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wd = 8'($urandom);
      end
      run_txn(0, $urandom_range(0, 9), 8'($urandom), 1'($urandom), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
